// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: default widths,
// FSM state encoding and the requester index type.
package dmem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 6;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef logic req_idx_t;

  localparam req_idx_t REQ0 = 1'b0;
  localparam req_idx_t REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker with its pointer register. The pointer names the
// requester that wins a tie and moves to the loser on every acceptance.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     enable,
  input  logic     valid0,
  input  logic     valid1,
  output logic     grant0,
  output logic     grant1,
  output logic     accept,
  output req_idx_t winner
);

  req_idx_t ptr;

  always_comb begin
    winner = REQ0;
    if (valid0 && valid1) winner = ptr;
    else if (valid1)      winner = REQ1;
    accept = enable && (valid0 || valid1);
    grant0 = accept && (winner == REQ0);
    grant1 = accept && (winner == REQ1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= REQ0;
    end else if (accept) begin
      ptr <= ~winner;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto a single-ported data memory. Each access
// takes three cycles: accept (IDLE), memory strobe (ACCESS), completion (RESP).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state, state_next;
  logic              accept;
  req_idx_t          winner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  req_idx_t          owner_q;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state == IDLE),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant0 (req0_ready),
    .grant1 (req1_ready),
    .accept (accept),
    .winner (winner)
  );

  always_comb begin
    state_next  = state;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    req0_rvalid = 1'b0;
    req1_rvalid = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_next = ACCESS;
      end
      ACCESS: begin
        mem_write  = we_q;
        mem_read   = !we_q;
        state_next = RESP;
      end
      RESP: begin
        req0_rvalid = (owner_q == REQ0);
        req1_rvalid = (owner_q == REQ1);
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The request is captured at acceptance so later input changes cannot
  // disturb the in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      owner_q    <= REQ0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      if (state == IDLE && accept) begin
        owner_q <= winner;
        if (winner == REQ1) begin
          we_q    <= req1_we;
          addr_q  <= req1_addr;
          wdata_q <= req1_wdata;
        end else begin
          we_q    <= req0_we;
          addr_q  <= req0_addr;
          wdata_q <= req0_wdata;
        end
      end
      if (state == ACCESS && !we_q) begin
        if (owner_q == REQ1) req1_rdata <= mem_rdata;
        else                 req0_rdata <= mem_rdata;
      end
    end
  end

endmodule
